conv3x3_pipe: RTL and testbench
===============================

CONV3X3_PIPE -- requirements
Module: conv3x3_pipe

Interface
Parameters:
REQ-001 SHALL provide parameter DW, default 10, pixel width (unsigned).
REQ-002 SHALL provide parameter CW, default 10, coefficient width (signed two's complement).
REQ-003 SHALL provide parameter SHIFT, default 0, round-right-shift applied before pixel output.
REQ-004 SHALL provide parameter ABS_MODE, default 0; 1 = magnitude output for edge detection.

Ports (AW = DW+CW+5):
REQ-005 SHALL provide port clk, input, 1, single clock, all logic rising-edge.
REQ-006 SHALL provide port aclr_n, input, 1; reset is asynchronous and active-low.
REQ-007 SHALL provide port clken, input, 1, pipeline advance enable.
REQ-008 SHALL provide port in_valid, input, 1, window valid.
REQ-009 SHALL provide port win, input, 9*DW, 3x3 window row-major; p0 (row1 col1) in [DW-1:0], p8 (row3 col3) in top slice.
REQ-010 SHALL provide port coef_we, input, 1, shadow coefficient write strobe.
REQ-011 SHALL provide port coef_addr, input, 4, coefficient index 0..8, same order as win.
REQ-012 SHALL provide port coef_data, input, CW, coefficient value.
REQ-013 SHALL provide port coef_swap, input, 1, copy shadow bank to active bank.
REQ-014 SHALL provide port out_valid, output, 1, result valid.
REQ-015 SHALL provide port result, output, AW, signed raw 9-tap sum.
REQ-016 SHALL provide port pix_out, output, DW, post-processed unsigned pixel.
REQ-017 SHALL provide port sat_flag, output, 1, pix_out clamped this sample.

Function
REQ-018 SHALL compute result = sum over k of p_k (zero-extended) times c_k (signed), exact, no overflow possible at width AW.
REQ-019 SHALL be a 3-stage pipeline: S1 registers nine products, S2 registers three row partial sums, S3 registers result, pix_out, sat_flag, out_valid.
REQ-020 SHALL produce outputs exactly 3 clken-high cycles after the sample is accepted; a sample is accepted when clken=1 and in_valid=1.
REQ-021 SHALL carry in_valid through a 3-bit valid shift register advanced only when clken=1; out_valid is its last stage.
REQ-022 SHALL, while clken=0, hold every pipeline register and all outputs unchanged; win and in_valid are ignored.
REQ-023 SHALL, when ABS_MODE=1, take the absolute value of result before post-processing; when ABS_MODE=0, pass result signed.
REQ-024 SHALL, when SHIFT>0, add 2^(SHIFT-1) then shift arithmetically right by SHIFT; when SHIFT=0, pass the value unchanged.
REQ-025 SHALL clamp the post-shift value to 0..2^DW-1 for pix_out, with sat_flag=1 whenever the clamp changed the value, else 0.
REQ-026 SHALL update result, pix_out and sat_flag only on stages holding valid data; bubbles leave the previous values held.
REQ-027 SHALL write coef_data to shadow[coef_addr] on any cycle with coef_we=1, independent of clken; addresses 9..15 are ignored.
REQ-028 SHALL copy all nine shadow coefficients to the active bank on a cycle with coef_swap=1, independent of clken.
REQ-029 SHALL include a same-cycle coef_we write in the copy when coef_we and coef_swap coincide.
REQ-030 SHALL make the active bank used by S1 change only at a swap; samples accepted on the swap cycle use the old bank, and later samples use the new bank.

Reset
REQ-031 SHALL, while aclr_n=0, clear out_valid, result, pix_out, sat_flag, the valid pipeline and all data registers to 0.
REQ-032 SHALL, on reset, set shadow and active banks to identity: c4=1, all others 0.
REQ-033 SHALL discard in-flight samples on a reset asserted mid-operation; the first out_valid after release comes 3 accepted-cycles after the first new sample.

Verification
REQ-034 SHALL cover identity passthrough: after reset, all taps 5 and p4=7, single valid -> out_valid 3 cycles later, result 7, pix_out 7, sat_flag 0.
REQ-035 SHALL cover Laplacian on a flat field: c4=8, others -1, swap, all pixels 100 -> result 0, pix_out 0, sat_flag 0.
REQ-036 SHALL cover saturation at DW=10, SHIFT=0: all coef 1, all pixels 1023 -> result 9207, pix_out 1023, sat_flag 1.
REQ-037 SHALL cover ABS_MODE=1 with Sobel-x (-1 0 1 / -2 0 2 / -1 0 1), left column 200, right 0 -> result -800, pix_out 800 clamped to 1023? No: 800, sat_flag 0.
REQ-038 SHALL cover stall: clken low 4 cycles mid-stream -> outputs frozen, no lost or duplicated samples, per-sample latency of 3 enabled cycles.
REQ-039 SHALL cover swap mid-stream plus reset: swap while streaming -> boundary sample matches REQ-030; aclr_n pulse mid-stream -> out_valid 0 immediately, identity coefficients restored.

Source files
------------

// File: rtl/conv3x3_pipe.sv
// 3x3 convolution over a 9-pixel window with double-buffered signed coefficients.
// Three registered stages (products, row sums, result/post-processing) advance on clken.
module conv3x3_pipe #(
  parameter int DW       = 10,
  parameter int CW       = 10,
  parameter int SHIFT    = 0,
  parameter int ABS_MODE = 0,
  localparam int AW      = DW + CW + 5
) (
  input  logic                 clk,
  input  logic                 aclr_n,
  input  logic                 clken,
  input  logic                 in_valid,
  input  logic [9*DW-1:0]      win,
  input  logic                 coef_we,
  input  logic [3:0]           coef_addr,
  input  logic signed [CW-1:0] coef_data,
  input  logic                 coef_swap,
  output logic                 out_valid,
  output logic signed [AW-1:0] result,
  output logic [DW-1:0]        pix_out,
  output logic                 sat_flag
);

  localparam int PW = DW + CW + 1;
  localparam int RW = PW + 2;
  localparam int XW = AW + 2;
  localparam int RND_SH = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic signed [XW-1:0] RND  = (SHIFT > 0) ? (XW'(1) << RND_SH) : XW'(0);
  localparam logic signed [XW-1:0] MAXP = XW'({DW{1'b1}});

  logic signed [CW-1:0] shadow [9];
  logic signed [CW-1:0] active [9];
  logic [DW-1:0]        pix    [9];
  logic signed [PW-1:0] prod   [9];
  logic signed [RW-1:0] row    [3];
  logic [2:0]           vpipe;

  logic signed [AW-1:0] sum_c;
  logic signed [XW-1:0] mag_c;
  logic signed [XW-1:0] shifted_c;
  logic [DW-1:0]        pix_c;
  logic                 sat_c;

  always_comb begin
    for (int k = 0; k < 9; k++) pix[k] = win[k*DW +: DW];
  end

  // A write landing on the swap cycle goes straight into the active bank too.
  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      for (int k = 0; k < 9; k++) begin
        shadow[k] <= (k == 4) ? CW'(1) : CW'(0);
        active[k] <= (k == 4) ? CW'(1) : CW'(0);
      end
    end else begin
      for (int k = 0; k < 9; k++) begin
        if (coef_we && coef_addr == 4'(k)) shadow[k] <= coef_data;
        if (coef_swap) active[k] <= (coef_we && coef_addr == 4'(k)) ? coef_data : shadow[k];
      end
    end
  end

  always_comb begin
    sum_c = AW'(row[0]) + AW'(row[1]) + AW'(row[2]);
    mag_c = XW'(sum_c);
    if (ABS_MODE != 0 && sum_c < 0) mag_c = -XW'(sum_c);
    shifted_c = (mag_c + RND) >>> SHIFT;
    pix_c = shifted_c[DW-1:0];
    sat_c = 1'b0;
    if (shifted_c < 0) begin
      pix_c = '0;
      sat_c = 1'b1;
    end else if (shifted_c > MAXP) begin
      pix_c = '1;
      sat_c = 1'b1;
    end
  end

  // Each stage only loads when its incoming slot holds a real sample, so bubbles keep old data.
  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      vpipe    <= '0;
      result   <= '0;
      pix_out  <= '0;
      sat_flag <= 1'b0;
      for (int k = 0; k < 9; k++) prod[k] <= '0;
      for (int r = 0; r < 3; r++) row[r] <= '0;
    end else if (clken) begin
      vpipe <= {vpipe[1:0], in_valid};
      if (in_valid) begin
        for (int k = 0; k < 9; k++)
          prod[k] <= PW'($signed({1'b0, pix[k]})) * PW'(active[k]);
      end
      if (vpipe[0]) begin
        for (int r = 0; r < 3; r++)
          row[r] <= RW'(prod[3*r]) + RW'(prod[3*r+1]) + RW'(prod[3*r+2]);
      end
      if (vpipe[1]) begin
        result   <= sum_c;
        pix_out  <= pix_c;
        sat_flag <= sat_c;
      end
    end
  end

  assign out_valid = vpipe[2];

endmodule

// File: tb/tb_conv3x3_pipe.sv
// Self-checking bench for conv3x3_pipe: three parameterisations share one stimulus stream
// and are compared against a dot-product model indexed by enabled-cycle count.
module tb_conv3x3_pipe;

  localparam int DW = 10;
  localparam int CW = 10;
  localparam int AW = DW + CW + 5;
  localparam int NMAX = 4096;

  logic                 clk = 1'b0;
  logic                 aclr_n;
  logic                 clken;
  logic                 in_valid;
  logic [9*DW-1:0]      win;
  logic                 coef_we;
  logic [3:0]           coef_addr;
  logic signed [CW-1:0] coef_data;
  logic                 coef_swap;

  logic                 ov  [3];
  logic signed [AW-1:0] res [3];
  logic [DW-1:0]        pix [3];
  logic                 sat [3];

  int px [9];
  int cset [9];
  int shadow_m [9];
  int active_m [9];
  bit acc_v [NMAX];
  int acc_r [NMAX];
  int en_cnt;
  int n_total = 0;
  int n_pass = 0;
  int n_fail = 0;

  conv3x3_pipe #(.DW(DW), .CW(CW), .SHIFT(0), .ABS_MODE(0)) dut_a (
    .clk(clk), .aclr_n(aclr_n), .clken(clken), .in_valid(in_valid), .win(win),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data), .coef_swap(coef_swap),
    .out_valid(ov[0]), .result(res[0]), .pix_out(pix[0]), .sat_flag(sat[0]));

  conv3x3_pipe #(.DW(DW), .CW(CW), .SHIFT(0), .ABS_MODE(1)) dut_b (
    .clk(clk), .aclr_n(aclr_n), .clken(clken), .in_valid(in_valid), .win(win),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data), .coef_swap(coef_swap),
    .out_valid(ov[1]), .result(res[1]), .pix_out(pix[1]), .sat_flag(sat[1]));

  conv3x3_pipe #(.DW(DW), .CW(CW), .SHIFT(3), .ABS_MODE(0)) dut_c (
    .clk(clk), .aclr_n(aclr_n), .clken(clken), .in_valid(in_valid), .win(win),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data), .coef_swap(coef_swap),
    .out_valid(ov[2]), .result(res[2]), .pix_out(pix[2]), .sat_flag(sat[2]));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 9; k++) begin
      shadow_m[k] = (k == 4) ? 1 : 0;
      active_m[k] = (k == 4) ? 1 : 0;
    end
    en_cnt = 0;
    for (int i = 0; i < NMAX; i++) acc_v[i] = 1'b0;
  endtask

  function automatic int dot();
    int s = 0;
    for (int k = 0; k < 9; k++) s += px[k] * active_m[k];
    return s;
  endfunction

  // Post-processing for instance d: a=(shift 0, signed), b=(shift 0, abs), c=(shift 3, signed).
  function automatic void post(input int r, input int d, output int p, output int s);
    int v = r;
    int sh = (d == 2) ? 3 : 0;
    if (d == 1 && v < 0) v = -v;
    if (sh > 0) v = (v + (1 << (sh - 1))) >>> sh;
    if (v < 0) begin p = 0; s = 1; end
    else if (v > 1023) begin p = 1023; s = 1; end
    else begin p = v; s = 0; end
  endfunction

  task automatic check_output();
    int exp_v = 0;
    int exp_r = 0;
    int ep, es;
    if (en_cnt >= 3) exp_v = int'(acc_v[en_cnt-3]);
    for (int i = en_cnt - 3; i >= 0; i--) begin
      if (acc_v[i]) begin
        exp_r = acc_r[i];
        break;
      end
    end
    for (int d = 0; d < 3; d++) begin
      if (exp_v == 0 && en_cnt < 3 && exp_r == 0) begin
        ep = 0; es = 0;
      end else begin
        post(exp_r, d, ep, es);
      end
      if (exp_r == 0) begin
        ep = 0; es = 0;
      end
      chk($sformatf("dut%0d.out_valid", d), 32'(ov[d]), exp_v);
      chk($sformatf("dut%0d.result", d), 32'(res[d]), exp_r);
      chk($sformatf("dut%0d.pix_out", d), 32'(pix[d]), ep);
      chk($sformatf("dut%0d.sat_flag", d), 32'(sat[d]), es);
    end
  endtask

  // One clock: the model absorbs this cycle's inputs, then outputs are checked 1ns after the edge.
  task automatic apply_stimulus();
    for (int k = 0; k < 9; k++) win[k*DW +: DW] = DW'(px[k]);
    if (clken) begin
      acc_v[en_cnt] = in_valid;
      acc_r[en_cnt] = dot();
      en_cnt++;
    end
    if (coef_we && coef_addr < 4'd9) shadow_m[coef_addr] = int'(coef_data);
    if (coef_swap) for (int k = 0; k < 9; k++) active_m[k] = shadow_m[k];
    @(posedge clk);
    #1;
    check_output();
  endtask

  task automatic load_coefs(input bit do_swap);
    clken = 1'b1;
    in_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      coef_we = 1'b1; coef_addr = 4'(k); coef_data = CW'(cset[k]);
      apply_stimulus();
    end
    coef_addr = 4'd12; coef_data = CW'(77);
    apply_stimulus();
    coef_addr = 4'd8; coef_data = CW'(cset[8]); coef_swap = do_swap;
    apply_stimulus();
    coef_we = 1'b0; coef_swap = 1'b0; coef_addr = 4'd0; coef_data = '0;
  endtask

  task automatic run_one();
    clken = 1'b1;
    in_valid = 1'b1;
    apply_stimulus();
    in_valid = 1'b0;
    apply_stimulus();
    apply_stimulus();
  endtask

  task automatic rand_px();
    for (int k = 0; k < 9; k++) px[k] = int'($urandom_range(0, 1023));
  endtask

  initial begin
    int p4;
    aclr_n = 1'b0; clken = 1'b0; in_valid = 1'b0; win = '0;
    coef_we = 1'b0; coef_addr = '0; coef_data = '0; coef_swap = 1'b0;
    for (int k = 0; k < 9; k++) px[k] = 0;
    model_reset();
    #1;
    check_output();
    #11 aclr_n = 1'b1;

    $display("[TB] identity passthrough");
    for (int k = 0; k < 9; k++) px[k] = 5;
    px[4] = 7;
    run_one();
    chk("identity.out_valid", 32'(ov[0]), 1);
    chk("identity.result", 32'(res[0]), 7);
    chk("identity.pix_out", 32'(pix[0]), 7);
    chk("identity.sat_flag", 32'(sat[0]), 0);
    apply_stimulus();

    $display("[TB] laplacian flat field");
    cset = '{-1, -1, -1, -1, 8, -1, -1, -1, -1};
    load_coefs(1'b1);
    for (int k = 0; k < 9; k++) px[k] = 100;
    run_one();
    chk("laplace.result", 32'(res[0]), 0);
    chk("laplace.pix_out", 32'(pix[0]), 0);
    chk("laplace.sat_flag", 32'(sat[0]), 0);

    $display("[TB] saturation");
    cset = '{1, 1, 1, 1, 1, 1, 1, 1, 1};
    load_coefs(1'b1);
    for (int k = 0; k < 9; k++) px[k] = 1023;
    run_one();
    chk("sat.result", 32'(res[0]), 9207);
    chk("sat.pix_out", 32'(pix[0]), 1023);
    chk("sat.sat_flag", 32'(sat[0]), 1);

    $display("[TB] sobel-x magnitude");
    cset = '{-1, 0, 1, -2, 0, 2, -1, 0, 1};
    load_coefs(1'b1);
    for (int k = 0; k < 9; k++) px[k] = (k % 3 == 0) ? 200 : ((k % 3 == 1) ? 50 : 0);
    run_one();
    chk("sobel.result", 32'(res[1]), -800);
    chk("sobel.abs_pix_out", 32'(pix[1]), 800);
    chk("sobel.abs_sat_flag", 32'(sat[1]), 0);
    chk("sobel.signed_pix_out", 32'(pix[0]), 0);
    chk("sobel.signed_sat_flag", 32'(sat[0]), 1);

    $display("[TB] extreme negative coefficients");
    cset = '{-512, -512, -512, -512, -512, -512, -512, -512, -512};
    load_coefs(1'b1);
    for (int k = 0; k < 9; k++) px[k] = 1023;
    run_one();
    chk("extreme.result", 32'(res[0]), -4713984);

    $display("[TB] stall mid-stream");
    for (int k = 0; k < 9; k++) cset[k] = int'($urandom_range(0, 40)) - 20;
    load_coefs(1'b1);
    for (int i = 0; i < 12; i++) begin
      clken = !(i >= 4 && i < 8);
      in_valid = 1'b1;
      rand_px();
      apply_stimulus();
    end
    clken = 1'b1; in_valid = 1'b0;
    for (int i = 0; i < 4; i++) apply_stimulus();

    $display("[TB] swap mid-stream");
    for (int k = 0; k < 9; k++) cset[k] = int'($urandom_range(0, 200)) - 100;
    load_coefs(1'b0);
    clken = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1;
      coef_swap = (i == 2);
      rand_px();
      apply_stimulus();
    end
    coef_swap = 1'b0; in_valid = 1'b0;
    for (int i = 0; i < 4; i++) apply_stimulus();

    $display("[TB] reset mid-stream");
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      rand_px();
      apply_stimulus();
    end
    in_valid = 1'b0;
    #1 aclr_n = 1'b0;
    #1;
    model_reset();
    check_output();
    chk("reset.out_valid", 32'(ov[0]), 0);
    #2 aclr_n = 1'b1;
    rand_px();
    p4 = px[4];
    run_one();
    chk("reset.identity_valid", 32'(ov[0]), 1);
    chk("reset.identity_result", 32'(res[0]), p4);
    apply_stimulus();

    $display("[TB] randomized traffic");
    for (int i = 0; i < 400; i++) begin
      clken = ($urandom_range(0, 3) != 0);
      in_valid = $urandom_range(0, 1) == 1;
      coef_we = ($urandom_range(0, 5) == 0);
      coef_addr = 4'($urandom_range(0, 15));
      coef_data = CW'($urandom_range(0, 1023));
      coef_swap = ($urandom_range(0, 15) == 0);
      rand_px();
      apply_stimulus();
    end
    clken = 1'b1; in_valid = 1'b0; coef_we = 1'b0; coef_swap = 1'b0;
    for (int i = 0; i < 4; i++) apply_stimulus();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
